// File: rtl/truth_table_scanner_if.sv
// rtl/truth_table_scanner_if.sv - stimulus/capture bundle between a truth-table scanner and its host
//
// Purpose: groups the scan request, applied vector, sampled z and result signals.
//   master : host side (drives start, z_in, expected)
//   slave  : scanner side (drives vec, busy, done, table_out, ones, mismatch, fail_idx)
// Ports (signals):
//   start      scan request
//   vec        applied input vector, N_IN bits
//   z_in       output of the block under scan
//   busy       scan in progress
//   done       one-cycle completion pulse
//   table_out  captured truth table, 2**N_IN bits
//   ones       minterm count, N_IN+1 bits
//   expected / mismatch / fail_idx  present only when TT_CHECK_EN is defined
interface truth_table_scanner_if #(
  parameter int N_IN = 5
);
  logic                 start;
  logic [N_IN-1:0]      vec;
  logic                 z_in;
  logic                 busy;
  logic                 done;
  logic [2**N_IN-1:0]   table_out;
  logic [N_IN:0]        ones;
`ifdef TT_CHECK_EN
  logic [2**N_IN-1:0]   expected;
  logic                 mismatch;
  logic [N_IN-1:0]      fail_idx;

  modport master (output start, z_in, expected,
                  input  vec, busy, done, table_out, ones, mismatch, fail_idx);
  modport slave  (input  start, z_in, expected,
                  output vec, busy, done, table_out, ones, mismatch, fail_idx);
`else
  modport master (output start, z_in,
                  input  vec, busy, done, table_out, ones);
  modport slave  (input  start, z_in,
                  output vec, busy, done, table_out, ones);
`endif
endinterface

// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - walks every input vector of a Boolean block and captures its truth table
//
// Purpose: drives vec = 0 .. 2**N_IN-1, holds each for SETTLE+1 cycles, samples z_in on the
//   last cycle into table_out[vec] and counts ones. done pulses once per completed scan.
// Optional feature: define TT_CHECK_EN to compare against a golden table (expected), flag a
//   sticky mismatch and record the first failing index (fail_idx).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    truth_table_scanner_if.slave (start, vec, z_in, busy, done, table_out, ones
//          [, expected, mismatch, fail_idx])
module truth_table_scanner #(
  parameter int N_IN   = 5,
  parameter int SETTLE = 1
) (
  input logic                   clk,
  input logic                   reset,
  truth_table_scanner_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, FIN} state_e;

  localparam int              TBL_W     = 2**N_IN;
  localparam logic [N_IN-1:0] VEC_LAST  = '1;
  localparam logic [3:0]      HOLD_LAST = 4'((SETTLE == 0) ? 0 : SETTLE - 1);
  // With no settle time, HOLD is skipped entirely and vectors advance SAMPLE->SAMPLE.
  localparam state_e          STEP_ST   = (SETTLE == 0) ? SAMPLE : HOLD;

  state_e             state_q, state_d;
  logic [N_IN-1:0]    vec_q, vec_d;
  logic [3:0]         hold_q, hold_d;
  logic               busy_q, busy_d;
  logic [TBL_W-1:0]   table_q, table_d;
  logic [N_IN:0]      ones_q, ones_d;
`ifdef TT_CHECK_EN
  logic [TBL_W-1:0]   expected_q, expected_d;
  logic               mismatch_q, mismatch_d;
  logic [N_IN-1:0]    fail_idx_q, fail_idx_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      hold_q     <= '0;
      busy_q     <= 1'b0;
      table_q    <= '0;
      ones_q     <= '0;
`ifdef TT_CHECK_EN
      expected_q <= '0;
      mismatch_q <= 1'b0;
      fail_idx_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      table_q    <= table_d;
      ones_q     <= ones_d;
`ifdef TT_CHECK_EN
      expected_q <= expected_d;
      mismatch_q <= mismatch_d;
      fail_idx_q <= fail_idx_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    table_d    = table_q;
    ones_d     = ones_q;
`ifdef TT_CHECK_EN
    expected_d = expected_q;
    mismatch_d = mismatch_q;
    fail_idx_d = fail_idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = STEP_ST;
          vec_d   = '0;
          hold_d  = '0;
          busy_d  = 1'b1;
          table_d = '0;
          ones_d  = '0;
`ifdef TT_CHECK_EN
          expected_d = bus.expected;
          mismatch_d = 1'b0;
          fail_idx_d = '0;
`endif
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = SAMPLE;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      SAMPLE: begin
        table_d[vec_q] = bus.z_in;
        ones_d         = ones_q + {{N_IN{1'b0}}, bus.z_in};
`ifdef TT_CHECK_EN
        if (bus.z_in != expected_q[vec_q]) begin
          // fail_idx keeps the first failing vector only.
          if (!mismatch_q) fail_idx_d = vec_q;
          mismatch_d = 1'b1;
        end
`endif
        if (vec_q == VEC_LAST) begin
          state_d = FIN;
        end else begin
          vec_d   = vec_q + 1'b1;
          state_d = STEP_ST;
        end
      end
      FIN: begin
        // start is not looked at here; the next request is taken from IDLE.
        busy_d  = 1'b0;
        vec_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.vec       = vec_q;
  assign bus.busy      = busy_q;
  assign bus.done      = (state_q == FIN);
  assign bus.table_out = table_q;
  assign bus.ones      = ones_q;
`ifdef TT_CHECK_EN
  assign bus.mismatch  = mismatch_q;
  assign bus.fail_idx  = fail_idx_q;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - directed self-checking bench for truth_table_scanner
module tb_truth_table_scanner;

  localparam logic [31:0] GOLDEN = 32'h307875EC;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] z_table;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  truth_table_scanner_if #(.N_IN(5)) if_a ();
  truth_table_scanner_if #(.N_IN(5)) if_b ();

  // Block under scan for dut_a: a lookup of the reference table; dut_b sees z = vec[0].
  assign if_a.z_in = z_table[if_a.vec];
  assign if_b.z_in = if_b.vec[0];

  truth_table_scanner #(.N_IN(5), .SETTLE(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  truth_table_scanner #(.N_IN(5), .SETTLE(3)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulses start on dut_a; lat counts the done cycle with the start-accepting edge's
  // following cycle as cycle 1, i.e. lat = edges after acceptance until done + 1.
  task automatic scan_a(output int lat);
    int n;
    if_a.start = 1'b1;
    step(1);
    if_a.start = 1'b0;
    n = 0;
    while (if_a.done !== 1'b1 && n < 300) begin
      step(1);
      n++;
    end
    lat = n + 1;
  endtask

  int lat, dcnt, didx, busy66, busy67, seen;

  initial begin
    reset = 1'b1;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    z_table = GOLDEN;
`ifdef TT_CHECK_EN
    if_a.expected = GOLDEN;
    if_b.expected = '0;
`endif
    step(3);
    reset = 1'b0;

    // Reset state
    chk("rst_vec",   if_a.vec, 0);
    chk("rst_busy",  if_a.busy, 0);
    chk("rst_done",  if_a.done, 0);
    chk("rst_table", if_a.table_out, 0);
    chk("rst_ones",  if_a.ones, 0);
    step(2);

    // 1: reference table
    scan_a(lat);
    chk("t1_latency", lat, 65);
    chk("t1_table",   if_a.table_out, 32'h307875EC);
    chk("t1_ones",    if_a.ones, 16);
    step(5);
    chk("t1_hold_table", if_a.table_out, 32'h307875EC);
    chk("t1_hold_ones",  if_a.ones, 16);

    // 2: all ones
    z_table = 32'hFFFFFFFF;
    scan_a(lat);
    chk("t2_latency", lat, 65);
    chk("t2_table",   if_a.table_out, 32'hFFFFFFFF);
    chk("t2_ones",    if_a.ones, 6'b100000);
    chk("t2_busy_at_done", if_a.busy, 1);
    step(1);
    chk("t2_busy_after", if_a.busy, 0);
    chk("t2_done_after", if_a.done, 0);
    step(2);

    // 3: start held for 100 cycles; edge 1 is the accepting edge
    z_table = GOLDEN;
    if_a.start = 1'b1;
    dcnt = 0; didx = 0; busy66 = 9; busy67 = 9;
    for (int i = 1; i <= 100; i++) begin
      step(1);
      if (if_a.done === 1'b1) begin
        dcnt++;
        didx = i;
      end
      if (i == 66) busy66 = int'(if_a.busy);
      if (i == 67) busy67 = int'(if_a.busy);
    end
    if_a.start = 1'b0;
    chk("t3_done_count", dcnt, 1);
    chk("t3_done_cycle", didx, 65);
    chk("t3_fin_start_ignored", busy66, 0);
    chk("t3_idle_start_taken",  busy67, 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(2);

    // 4: reset at cycle 20 of a scan
    if_a.start = 1'b1;
    step(1);
    if_a.start = 1'b0;
    step(19);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t4_vec",   if_a.vec, 0);
    chk("t4_busy",  if_a.busy, 0);
    chk("t4_table", if_a.table_out, 0);
    chk("t4_ones",  if_a.ones, 0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      step(1);
      if (if_a.done === 1'b1) seen = 1;
    end
    chk("t4_no_done", seen, 0);

    // 5: SETTLE=3, z = vec[0]; vec after edge n of the scan is n/4
    if_b.start = 1'b1;
    step(1);
    if_b.start = 1'b0;
    lat = 0;
    while (if_b.done !== 1'b1 && lat < 400) begin
      if (lat == 3)   chk("t5_vec_n3",   if_b.vec, 0);
      if (lat == 4)   chk("t5_vec_n4",   if_b.vec, 1);
      if (lat == 127) chk("t5_vec_n127", if_b.vec, 31);
      step(1);
      lat++;
    end
    chk("t5_latency", lat + 1, 129);
    chk("t5_table",   if_b.table_out, 32'hAAAAAAAA);
    chk("t5_ones",    if_b.ones, 16);
    step(2);

`ifdef TT_CHECK_EN
    // 6: golden comparison
    if_a.expected = GOLDEN;
    z_table = GOLDEN ^ 32'h00000200;
    scan_a(lat);
    chk("t6_mismatch", if_a.mismatch, 1);
    chk("t6_fail_idx", if_a.fail_idx, 9);
    step(2);
    z_table = GOLDEN;
    scan_a(lat);
    chk("t6_clean_mismatch", if_a.mismatch, 0);
    step(2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
